// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
// Shared definitions for the pipeline sequencer: the divide-tracking state
// encoding, the default divider latency, the width of the divide countdown
// and a register-compare helper used by the hazard logic.
// No ports (package).

package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } ctrlState_t;

    localparam int DIV_CYCLES_DEFAULT = 32;
    localparam int CNT_W              = 6;

    // Register 0 is hard-wired to zero, so a write to it never creates a
    // dependency; every hazard compare goes through this helper.
    function automatic logic regMatch(input logic [4:0] srcReg,
                                      input logic [4:0] dstReg);
        return (dstReg != 5'd0) && (srcReg == dstReg);
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if
// Bundle between the core top level and the pipeline sequencer.
// Core -> sequencer: D-stage sources and control-flow type, E/M destination
//   and type, divide-in-E, M-stage memory handshake, M-stage exception.
// Sequencer -> core: per-stage stall/flush strobes and divider control.
// Modports: master = core side, slave = pipe_ctrl side.

interface pipe_ctrl_if;

    logic [4:0] rsD;
    logic [4:0] rtD;
    logic       branchD;
    logic       jrD;
    logic [4:0] writeregE;
    logic       RegWriteE;
    logic       MemtoRegE;
    logic [4:0] writeregM;
    logic       MemtoRegM;
    logic       divE;
    logic       dmem_reqM;
    logic       dmem_readyM;
    logic       exceptM;

    logic       stallF;
    logic       stallD;
    logic       stallE;
    logic       stallM;
    logic       stallW;
    logic       flushD;
    logic       flushE;
    logic       flushM;
    logic       flushW;
    logic       div_start;
    logic       div_abort;
    logic       div_busy;

    modport master (
        output rsD, rtD, branchD, jrD, writeregE, RegWriteE, MemtoRegE,
               writeregM, MemtoRegM, divE, dmem_reqM, dmem_readyM, exceptM,
        input  stallF, stallD, stallE, stallM, stallW,
               flushD, flushE, flushM, flushW,
               div_start, div_abort, div_busy
    );

    modport slave (
        input  rsD, rtD, branchD, jrD, writeregE, RegWriteE, MemtoRegE,
               writeregM, MemtoRegM, divE, dmem_reqM, dmem_readyM, exceptM,
        output stallF, stallD, stallE, stallM, stallW,
               flushD, flushE, flushM, flushW,
               div_start, div_abort, div_busy
    );

endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// hazard_detect
// Purely combinational data-hazard terms for the D-stage instruction.
// Inputs : rsD/rtD (D sources), branchD/jrD (D compares operands in D),
//          writeregE/RegWriteE/MemtoRegE (E producer), writeregM/MemtoRegM
//          (M load).
// Outputs: lu (load-use against E), br (branch/jr operand not yet available).

module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic       branchD,
    input  logic       jrD,
    input  logic [4:0] writeregE,
    input  logic       RegWriteE,
    input  logic       MemtoRegE,
    input  logic [4:0] writeregM,
    input  logic       MemtoRegM,
    output logic       lu,
    output logic       br
);

    logic rsPending;
    logic rtPending;

    // A load in E cannot forward into E next cycle, so either source needing
    // it costs one bubble.
    // Branches and jr resolve in D, so any E result or a still-loading M value
    // is not ready yet; jr only reads rs.
    always_comb begin
        lu = MemtoRegE && RegWriteE &&
             (regMatch(rsD, writeregE) || regMatch(rtD, writeregE));

        rsPending = (RegWriteE && regMatch(rsD, writeregE)) ||
                    (MemtoRegM && regMatch(rsD, writeregM));
        rtPending = (RegWriteE && regMatch(rtD, writeregE)) ||
                    (MemtoRegM && regMatch(rtD, writeregM));

        br = (branchD && (rsPending || rtPending)) || (jrD && rsPending);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl
// Pipeline sequencer for the five-stage core. Produces the stall and flush
// strobes for the F/D, D/E, E/M and M/W registers and drives the divider.
// Ports: clk, reset (synchronous, active high), bus (pipe_ctrl_if.slave)
//        carrying the hazard inputs and all strobe/divider outputs.
// Parameter DIV_CYCLES: divider latency counted from the div_start cycle,
// legal 2..63.

module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    pipe_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    ctrlState_t        state;
    ctrlState_t        stateNext;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cntNext;

    logic lu;
    logic br;
    logic mw;
    logic divHold;

    logic stallF, stallD, stallE, stallM;
    logic flushD, flushE, flushM, flushW;
    logic divStart, divAbort, divBusy;

    hazard_detect uHazard (
        .rsD       (bus.rsD),
        .rtD       (bus.rtD),
        .branchD   (bus.branchD),
        .jrD       (bus.jrD),
        .writeregE (bus.writeregE),
        .RegWriteE (bus.RegWriteE),
        .MemtoRegE (bus.MemtoRegE),
        .writeregM (bus.writeregM),
        .MemtoRegM (bus.MemtoRegM),
        .lu        (lu),
        .br        (br)
    );

    // State and divide countdown; reset returns to IDLE without aborting the
    // divider, which sees the same reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    // Next-state: an exception cancels any divide. The countdown keeps
    // running through memory waits so the divider finishes on schedule, but a
    // finished divide stays in DIV_DONE until M is free to accept it. A divide
    // is not started while M is waiting; it is retried once the wait ends.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        mw        = bus.dmem_reqM && !bus.dmem_readyM;

        if (bus.exceptM) begin
            stateNext = IDLE;
            cntNext   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.divE && !mw) begin
                        stateNext = DIV_BUSY;
                        cntNext   = CNT_LOAD;
                    end
                end
                DIV_BUSY: begin
                    cntNext = cnt - CNT_LAST;
                    if (cnt == CNT_LAST) begin
                        stateNext = DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    if (!mw) begin
                        stateNext = IDLE;
                    end
                end
                default: begin
                    stateNext = IDLE;
                    cntNext   = '0;
                end
            endcase
        end
    end

    // Output priority mux. The memory wait holds everything up to M and
    // bubbles W; the divide hold freezes up to E and bubbles M; hazards
    // freeze F/D and bubble E. DIV_DONE releases E, so divE is not treated
    // as a new divide there.
    always_comb begin
        stallF   = 1'b0;
        stallD   = 1'b0;
        stallE   = 1'b0;
        stallM   = 1'b0;
        flushD   = 1'b0;
        flushE   = 1'b0;
        flushM   = 1'b0;
        flushW   = 1'b0;
        divStart = 1'b0;
        divAbort = 1'b0;
        divHold  = (state == DIV_BUSY) || ((state == IDLE) && bus.divE);

        if (reset) begin
            flushD = 1'b1;
            flushE = 1'b1;
            flushM = 1'b1;
            flushW = 1'b1;
        end else if (bus.exceptM) begin
            flushD   = 1'b1;
            flushE   = 1'b1;
            flushM   = 1'b1;
            divAbort = (state == DIV_BUSY) || (state == DIV_DONE);
        end else if (mw) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushW = 1'b1;
        end else if (divHold) begin
            stallF   = 1'b1;
            stallD   = 1'b1;
            stallE   = 1'b1;
            flushM   = 1'b1;
            divStart = (state == IDLE);
        end else if (lu || br) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end

        divBusy = (state == DIV_BUSY) && !reset;
    end

    assign bus.stallF    = stallF;
    assign bus.stallD    = stallD;
    assign bus.stallE    = stallE;
    assign bus.stallM    = stallM;
    assign bus.stallW    = 1'b0;
    assign bus.flushD    = flushD;
    assign bus.flushE    = flushE;
    assign bus.flushM    = flushM;
    assign bus.flushW    = flushW;
    assign bus.div_start = divStart;
    assign bus.div_abort = divAbort;
    assign bus.div_busy  = divBusy;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl
// Self-checking bench for pipe_ctrl with DIV_CYCLES = 4. Directed scenarios
// followed by random traffic, all checked cycle by cycle against a model that
// tracks the divide as "cycles elapsed since div_start".
// Output vector layout (bit 11..0): stallF stallD stallE stallM stallW
// flushD flushE flushM flushW div_start div_abort div_busy.

module tb_pipe_ctrl;

    localparam int DC = 4;

    localparam logic [11:0] V_NONE  = 12'b0000_0000_0000;
    localparam logic [11:0] V_RESET = 12'b0000_0111_1000;
    localparam logic [11:0] V_HAZ   = 12'b1100_0010_0000;
    localparam logic [11:0] V_MWAIT = 12'b1111_0000_1000;

    logic clk;
    logic reset;

    int testCount;
    int failCount;

    bit mActive;
    int mElapsed;

    pipe_ctrl_if bus ();

    pipe_ctrl #(.DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        testCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit regUse(input logic [4:0] r, input logic [4:0] w,
                                  input logic en);
        return en && (w != 5'd0) && (w == r);
    endfunction

    function automatic bit srcPending(input logic [4:0] r);
        return regUse(r, bus.writeregE, bus.RegWriteE) ||
               regUse(r, bus.writeregM, bus.MemtoRegM);
    endfunction

    function automatic logic [11:0] modelExpect();
        logic [11:0] e;
        bit lu, br, mw, divRunning;
        e  = '0;
        lu = regUse(bus.rsD, bus.writeregE, bus.MemtoRegE && bus.RegWriteE) ||
             regUse(bus.rtD, bus.writeregE, bus.MemtoRegE && bus.RegWriteE);
        br = (bus.branchD && (srcPending(bus.rsD) || srcPending(bus.rtD))) ||
             (bus.jrD && srcPending(bus.rsD));
        mw = bus.dmem_reqM && !bus.dmem_readyM;
        divRunning = mActive && (mElapsed < DC);
        if (reset) begin
            e[6:3] = 4'b1111;
        end else if (bus.exceptM) begin
            e[6:4] = 3'b111;
            e[1]   = mActive;
        end else if (mw) begin
            e[11:8] = 4'b1111;
            e[3]    = 1'b1;
        end else if (divRunning || (!mActive && bus.divE)) begin
            e[11:9] = 3'b111;
            e[4]    = 1'b1;
            e[2]    = !mActive;
        end else if (lu || br) begin
            e[11:10] = 2'b11;
            e[5]     = 1'b1;
        end
        e[0] = divRunning && !reset;
        return e;
    endfunction

    task automatic modelUpdate();
        bit mw;
        mw = bus.dmem_reqM && !bus.dmem_readyM;
        if (reset || bus.exceptM) begin
            mActive = 1'b0;
        end else if (!mActive) begin
            if (bus.divE && !mw) begin
                mActive  = 1'b1;
                mElapsed = 1;
            end
        end else if (mElapsed < DC) begin
            mElapsed++;
        end else if (!mw) begin
            mActive = 1'b0;
        end
    endtask

    // One clock: sample mid-cycle, compare with the model, advance the model
    // with the inputs the DUT is about to clock in.
    task automatic runCycle(input string tag, output logic [11:0] obs);
        @(negedge clk);
        obs = {bus.stallF, bus.stallD, bus.stallE, bus.stallM, bus.stallW,
               bus.flushD, bus.flushE, bus.flushM, bus.flushW,
               bus.div_start, bus.div_abort, bus.div_busy};
        checkOutput(tag, 32'(obs), 32'(modelExpect()));
        modelUpdate();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        reset           = 1'b0;
        bus.rsD         = '0;
        bus.rtD         = '0;
        bus.branchD     = 1'b0;
        bus.jrD         = 1'b0;
        bus.writeregE   = '0;
        bus.RegWriteE   = 1'b0;
        bus.MemtoRegE   = 1'b0;
        bus.writeregM   = '0;
        bus.MemtoRegM   = 1'b0;
        bus.divE        = 1'b0;
        bus.dmem_reqM   = 1'b0;
        bus.dmem_readyM = 1'b0;
        bus.exceptM     = 1'b0;
    endtask

    task automatic applyStimulus();
        bus.rsD         = 5'($urandom_range(0, 3));
        bus.rtD         = 5'($urandom_range(0, 3));
        bus.branchD     = ($urandom_range(0, 3) == 0);
        bus.jrD         = ($urandom_range(0, 5) == 0);
        bus.writeregE   = 5'($urandom_range(0, 3));
        bus.RegWriteE   = $urandom_range(0, 1);
        bus.MemtoRegE   = $urandom_range(0, 1);
        bus.writeregM   = 5'($urandom_range(0, 3));
        bus.MemtoRegM   = $urandom_range(0, 1);
        bus.divE        = ($urandom_range(0, 5) == 0);
        bus.dmem_reqM   = ($urandom_range(0, 2) == 0);
        bus.dmem_readyM = $urandom_range(0, 1);
        bus.exceptM     = ($urandom_range(0, 19) == 0);
        reset           = ($urandom_range(0, 79) == 0);
    endtask

    initial begin
        logic [11:0] obs;
        int          starts;
        int          eHolds;
        int          mHolds;
        int          busyCycles;

        testCount = 0;
        failCount = 0;
        mActive   = 1'b0;
        mElapsed  = 0;

        clearInputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        runCycle("reset", obs);
        checkOutput("reset_vec", 32'(obs), 32'(V_RESET));

        // Load-use: lw $2 in E, add $3,$2,$4 in D.
        clearInputs();
        bus.rsD = 5'd2; bus.rtD = 5'd4;
        bus.writeregE = 5'd2; bus.RegWriteE = 1'b1; bus.MemtoRegE = 1'b1;
        runCycle("lu_stall", obs);
        checkOutput("lu_vec", 32'(obs), 32'(V_HAZ));
        bus.RegWriteE = 1'b0; bus.MemtoRegE = 1'b0; bus.writeregE = 5'd0;
        bus.writeregM = 5'd2; bus.MemtoRegM = 1'b1;
        runCycle("lu_release", obs);
        checkOutput("lu_release_vec", 32'(obs), 32'(V_NONE));
        clearInputs();
        bus.rsD = 5'd0; bus.rtD = 5'd4;
        bus.writeregE = 5'd0; bus.RegWriteE = 1'b1; bus.MemtoRegE = 1'b1;
        runCycle("lu_reg0", obs);
        checkOutput("lu_reg0_vec", 32'(obs), 32'(V_NONE));

        // Branch: beq $5,$6 with a load to $6 in M; jr with only rt matching.
        clearInputs();
        bus.branchD = 1'b1; bus.rsD = 5'd5; bus.rtD = 5'd6;
        bus.writeregM = 5'd6; bus.MemtoRegM = 1'b1;
        runCycle("br_mload", obs);
        checkOutput("br_mload_vec", 32'(obs), 32'(V_HAZ));
        bus.branchD = 1'b0; bus.jrD = 1'b1; bus.rsD = 5'd7;
        runCycle("jr_rt_only", obs);
        checkOutput("jr_rt_only_vec", 32'(obs), 32'(V_NONE));

        // Divide with divE held through DIV_DONE.
        clearInputs();
        bus.divE = 1'b1;
        starts = 0; eHolds = 0;
        for (int i = 0; i <= DC; i++) begin
            runCycle("div_run", obs);
            starts += int'(obs[2]);
            eHolds += int'(obs[9]);
            if (i == DC) checkOutput("div_done_vec", 32'(obs), 32'(V_NONE));
        end
        checkOutput("div_start_count", 32'(starts), 32'(1));
        checkOutput("div_stallE_count", 32'(eHolds), 32'(DC));

        // Memory wait of 3 cycles starting on the 2nd DIV_BUSY cycle.
        clearInputs();
        bus.divE = 1'b1;
        mHolds = 0; busyCycles = 0;
        for (int i = 0; i < 7; i++) begin
            bus.dmem_reqM   = (i >= 2 && i <= 4);
            bus.dmem_readyM = 1'b0;
            if (i >= 5) bus.divE = 1'b0;
            runCycle("div_mwait", obs);
            mHolds     += int'(obs[8]);
            busyCycles += int'(obs[0]);
            if (i == 4) checkOutput("mwait_done_vec", 32'(obs), 32'(V_MWAIT));
            if (i == 5) checkOutput("mwait_release_vec", 32'(obs), 32'(V_NONE));
        end
        checkOutput("mwait_stallM_count", 32'(mHolds), 32'(3));
        checkOutput("mwait_busy_count", 32'(busyCycles), 32'(DC - 1));

        // Exception on the 2nd DIV_BUSY cycle.
        clearInputs();
        bus.divE = 1'b1;
        runCycle("exc_start", obs);
        runCycle("exc_busy1", obs);
        bus.exceptM = 1'b1;
        runCycle("exc_hit", obs);
        checkOutput("exc_vec", 32'(obs[11:1]), 32'(11'b0000_0111_001));
        bus.exceptM = 1'b0; bus.divE = 1'b0;
        runCycle("exc_after", obs);
        checkOutput("exc_after_vec", 32'(obs), 32'(V_NONE));

        // Reset on the 2nd DIV_BUSY cycle.
        clearInputs();
        bus.divE = 1'b1;
        runCycle("rst_start", obs);
        runCycle("rst_busy1", obs);
        reset = 1'b1;
        runCycle("rst_hit", obs);
        checkOutput("rst_mid_vec", 32'(obs), 32'(V_RESET));
        reset = 1'b0; bus.divE = 1'b0;
        runCycle("rst_after", obs);
        checkOutput("rst_after_vec", 32'(obs), 32'(V_NONE));

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus();
            runCycle("random", obs);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
